// File: rtl/bcd_conv_arbiter.sv
// Shared double-dabble binary-to-BCD converter with a two-requester round-robin
// arbiter in front; results are returned over valid/ready tagged with the requester ID.
module bcd_conv_arbiter #(
  parameter int WIDTH  = 27,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a_valid,
  input  logic [WIDTH-1:0]      req_a_data,
  output logic                  req_a_ready,
  input  logic                  req_b_valid,
  input  logic [WIDTH-1:0]      req_b_data,
  output logic                  req_b_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_id,
  output logic                  out_overflow,
  output logic                  busy
);

  localparam int ACC_W = 4 * (DIGITS + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0]      MAX_VAL = pow10(DIGITS) - 64'd1;
  localparam logic [BCD_W-1:0] NINES   = {DIGITS{4'h9}};

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
  function automatic logic [ACC_W-1:0] dabble_step(input logic [ACC_W-1:0] acc, input logic b);
    logic [ACC_W-1:0] r;
    r = acc;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (acc[4*i +: 4] >= 4'd5) r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      else                       r[4*i +: 4] = acc[4*i +: 4];
    end
    return {r[ACC_W-2:0], b};
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t             state_r, state_next_s;
  logic               last_grant_r;     // 1 = B was granted last
  logic [WIDTH-1:0]   bin_r;
  logic [ACC_W-1:0]   acc_r, acc_shift_s;
  logic [CNT_W-1:0]   count_r;
  logic               id_r, ovf_r;
  logic               out_valid_r, out_id_r, out_overflow_r, busy_r;
  logic [BCD_W-1:0]   out_bcd_r;
  logic               grant_a_s, grant_b_s, accept_s;
  logic [WIDTH-1:0]   sel_data_s;

  // Round-robin grant, only offered while idle and out of reset.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (!rst && state_r == IDLE) begin
      if (req_a_valid && req_b_valid) begin
        if (last_grant_r) grant_a_s = 1'b1;
        else              grant_b_s = 1'b1;
      end else if (req_a_valid) begin
        grant_a_s = 1'b1;
      end else if (req_b_valid) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b0;
      end
    end else begin
      grant_b_s = 1'b0;
    end
  end

  assign accept_s    = grant_a_s | grant_b_s;
  assign sel_data_s  = grant_b_s ? req_b_data : req_a_data;
  assign acc_shift_s = dabble_step(acc_r, bin_r[WIDTH-1]);

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_next_s = SHIFT;
               else          state_next_s = IDLE;
      SHIFT:   if (count_r == CNT_W'(1)) state_next_s = DONE;
               else                      state_next_s = SHIFT;
      DONE:    if (out_valid_r && out_ready) state_next_s = IDLE;
               else                          state_next_s = DONE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
    end
  end

  // Capture, shift engine and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r   <= 1'b1;
      bin_r          <= '0;
      acc_r          <= '0;
      count_r        <= '0;
      id_r           <= 1'b0;
      ovf_r          <= 1'b0;
      out_valid_r    <= 1'b0;
      out_bcd_r      <= '0;
      out_id_r       <= 1'b0;
      out_overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            bin_r        <= sel_data_s;
            id_r         <= grant_b_s;
            last_grant_r <= grant_b_s;
            ovf_r        <= (64'(sel_data_s) > MAX_VAL);
            acc_r        <= '0;
            count_r      <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          acc_r   <= acc_shift_s;
          bin_r   <= {bin_r[WIDTH-2:0], 1'b0};
          count_r <= count_r - CNT_W'(1);
          if (count_r == CNT_W'(1)) begin
            out_bcd_r      <= ovf_r ? NINES : acc_shift_s[BCD_W-1:0];
            out_id_r       <= id_r;
            out_overflow_r <= ovf_r;
            out_valid_r    <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign req_a_ready  = grant_a_s;
  assign req_b_ready  = grant_b_s;
  assign out_valid    = out_valid_r;
  assign out_bcd      = out_bcd_r;
  assign out_id       = out_id_r;
  assign out_overflow = out_overflow_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed self-checking bench for bcd_conv_arbiter with hand-computed BCD results.
module tb_bcd_conv_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_a_valid, req_b_valid, req_a_ready, req_b_ready;
  logic [26:0] req_a_data, req_b_data;
  logic        out_valid, out_ready, out_id, out_overflow, busy;
  logic [31:0] out_bcd;

  int checks   = 0;
  int failures = 0;

  bcd_conv_arbiter dut (
    .clk(clk), .rst(rst),
    .req_a_valid(req_a_valid), .req_a_data(req_a_data), .req_a_ready(req_a_ready),
    .req_b_valid(req_b_valid), .req_b_data(req_b_data), .req_b_ready(req_b_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
    .out_id(out_id), .out_overflow(out_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) at negedges for out_valid; returns number of posedges waited.
  task automatic wait_out(input string tag, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); cyc++; @(negedge clk);
    end
    if (!out_valid) check_val({tag, "_timeout"}, 64'(out_valid), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Single conversion on one requester, out_ready assumed high.
  task automatic run_one(input string tag, input logic sel_b, input logic [26:0] data,
                         input logic [31:0] exp_bcd, input logic exp_ovf);
    int cyc;
    @(negedge clk);
    if (sel_b) begin req_b_valid = 1'b1; req_b_data = data; end
    else       begin req_a_valid = 1'b1; req_a_data = data; end
    #1;
    check_val({tag, "_ready"}, 64'(sel_b ? req_b_ready : req_a_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    wait_out(tag, cyc);
    check_val({tag, "_bcd"}, 64'(out_bcd), 64'(exp_bcd));
    check_val({tag, "_id"},  64'(out_id), 64'(sel_b));
    check_val({tag, "_ovf"}, 64'(out_overflow), 64'(exp_ovf));
  endtask

  initial begin
    int cyc;
    logic [31:0] held;
    rst = 1'b1; req_a_valid = 1'b0; req_b_valid = 1'b0;
    req_a_data = '0; req_b_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_bcd",   64'(out_bcd), 64'd0);
    check_val("rst_busy",      64'(busy), 64'd0);
    check_val("rst_id_ovf",    64'({out_id, out_overflow}), 64'd0);

    // 1: latency and basic conversion
    req_a_valid = 1'b1; req_a_data = 27'd12345678;
    #1;
    check_val("t1_ready_a", 64'(req_a_ready), 64'd1);
    check_val("t1_ready_b", 64'(req_b_ready), 64'd0);
    @(posedge clk); cyc = 1;
    @(negedge clk); req_a_valid = 1'b0;
    while (!out_valid && cyc < 100) begin @(posedge clk); cyc++; @(negedge clk); end
    check_val("t1_latency", 64'(cyc), 64'd28);
    check_val("t1_bcd", 64'(out_bcd), 64'h12345678);
    check_val("t1_id",  64'(out_id), 64'd0);
    check_val("t1_ovf", 64'(out_overflow), 64'd0);

    // 2: both held valid, alternation A,B,A,B
    do_reset();
    req_a_valid = 1'b1; req_a_data = 27'd2024;
    req_b_valid = 1'b1; req_b_data = 27'd99999999;
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      #1;
      while (!(req_a_ready || req_b_ready) && cyc < 100) begin @(negedge clk); #1; cyc++; end
      check_val("t2_grant_a", 64'(req_a_ready), 64'((i % 2) == 0));
      @(posedge clk);
      @(negedge clk);
      wait_out("t2", cyc);
      check_val("t2_id",  64'(out_id), 64'((i % 2) == 1));
      check_val("t2_bcd", 64'(out_bcd), (i % 2) ? 64'h99999999 : 64'h2024);
      check_val("t2_ovf", 64'(out_overflow), 64'd0);
      @(negedge clk);
    end
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    repeat (40) @(negedge clk);

    // 3: boundaries
    run_one("t3_allones", 1'b0, 27'd134217727, 32'h99999999, 1'b1);
    run_one("t3_1e8",     1'b0, 27'd100000000, 32'h99999999, 1'b1);
    run_one("t3_zero",    1'b0, 27'd0,         32'h00000000, 1'b0);
    run_one("t3_1e7",     1'b0, 27'd10000000,  32'h10000000, 1'b0);
    run_one("t3_max",     1'b1, 27'd99999999,  32'h99999999, 1'b0);

    // 4: backpressure in DONE with a pending B request
    @(negedge clk);
    out_ready = 1'b0;
    req_a_valid = 1'b1; req_a_data = 27'd7;
    @(posedge clk); @(negedge clk);
    req_a_valid = 1'b0; req_b_valid = 1'b1; req_b_data = 27'd4096;
    wait_out("t4a", cyc);
    held = out_bcd;
    check_val("t4_bcd", 64'(out_bcd), 64'h7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check_val("t4_hold_valid", 64'(out_valid), 64'd1);
      check_val("t4_hold_bcd",   64'(out_bcd), 64'(held));
      check_val("t4_hold_ready", 64'({req_a_ready, req_b_ready}), 64'd0);
      check_val("t4_hold_busy",  64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk); #1;
    check_val("t4_idle_valid", 64'(out_valid), 64'd0);
    check_val("t4_ready_b",    64'(req_b_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    req_b_valid = 1'b0;
    wait_out("t4b", cyc);
    check_val("t4b_bcd", 64'(out_bcd), 64'h4096);
    check_val("t4b_id",  64'(out_id), 64'd1);

    // 5: reset during SHIFT
    @(negedge clk);
    req_a_valid = 1'b1; req_a_data = 27'd11111;
    @(posedge clk); @(negedge clk);
    req_a_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1; req_a_valid = 1'b1; req_a_data = 27'd54321;
    req_b_valid = 1'b1; req_b_data = 27'd1;
    #1;
    check_val("t5_rst_ready", 64'({req_a_ready, req_b_ready}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("t5_out_valid", 64'(out_valid), 64'd0);
    check_val("t5_busy",      64'(busy), 64'd0);
    check_val("t5_grant_a",   64'({req_a_ready, req_b_ready}), 64'b10);
    @(posedge clk); @(negedge clk);
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    wait_out("t5", cyc);
    check_val("t5_bcd", 64'(out_bcd), 64'h00054321);
    check_val("t5_id",  64'(out_id), 64'd0);

    // 6: B pulse during SHIFT is ignored
    @(negedge clk);
    req_a_valid = 1'b1; req_a_data = 27'd4321;
    @(posedge clk); @(negedge clk);
    req_a_valid = 1'b0;
    repeat (3) @(negedge clk);
    req_b_valid = 1'b1; req_b_data = 27'd888;
    #1;
    check_val("t6_ready_b_shift", 64'(req_b_ready), 64'd0);
    @(negedge clk);
    req_b_valid = 1'b0;
    wait_out("t6", cyc);
    check_val("t6_bcd", 64'(out_bcd), 64'h4321);
    check_val("t6_id",  64'(out_id), 64'd0);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid || busy) cyc++;
    end
    check_val("t6_no_b_conv", 64'(cyc), 64'd0);
    check_val("t6_bcd_hold",  64'(out_bcd), 64'h4321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
